// File: rtl/core.sv
// Multi-cycle RV32I-subset core: FETCH -> EXEC (-> MEM for loads) over one
// shared word-addressed memory port with a one-cycle registered read.
module core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        cpu_rstn,
  output logic [31:0] rd_addr,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        wren,
  input  logic [31:0] rd_data
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {FETCH, EXEC, MEM} state_t;

  state_t      state, state_n;
  logic [31:0] current_pc, pc_n;
  logic [31:0] ir;
  logic [31:0] regs [32];

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] pc_plus4, addr_i, addr_s;
  logic        ir_load, rf_we;
  logic [31:0] rf_wdata;
  logic        imm_legal, reg_legal, imm_alt;

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (f3)
      3'b000: r = alt ? (a - b) : (a + b);
      3'b001: r = a << b[4:0];
      3'b010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011: r = (a < b) ? 32'd1 : 32'd0;
      3'b100: r = a ^ b;
      3'b101: begin
        // kept as separate assignments so the arithmetic shift stays signed
        if (alt) r = $signed(a) >>> b[4:0];
        else     r = a >> b[4:0];
      end
      3'b110: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic br_taken(input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] b);
    logic t;
    case (f3)
      3'b000:  t = (a == b);
      3'b001:  t = (a != b);
      3'b100:  t = ($signed(a) <  $signed(b));
      3'b101:  t = ($signed(a) >= $signed(b));
      3'b110:  t = (a <  b);
      3'b111:  t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // In EXEC the instruction arrives on rd_data; afterwards it lives in IR.
  assign instr  = (state == EXEC) ? rd_data : ir;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign pc_plus4 = current_pc + 32'd4;
  assign addr_i   = rs1_val + imm_i;
  assign addr_s   = rs1_val + imm_s;

  always_comb begin
    imm_alt   = 1'b0;
    imm_legal = 1'b1;
    if (funct3 == 3'b001) begin
      imm_legal = (funct7 == 7'b0000000);
    end else if (funct3 == 3'b101) begin
      imm_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
      imm_alt   = funct7[5];
    end
    reg_legal = (funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
  end

  always_comb begin
    state_n  = state;
    pc_n     = current_pc;
    ir_load  = 1'b0;
    rf_we    = 1'b0;
    rf_wdata = '0;
    rd_addr  = current_pc >> 2;
    wr_addr  = '0;
    wr_data  = '0;
    wren     = 1'b0;
    case (state)
      FETCH: state_n = EXEC;
      EXEC: begin
        ir_load = 1'b1;
        state_n = FETCH;
        pc_n    = pc_plus4;
        case (opcode)
          OP_LUI: begin
            rf_we    = 1'b1;
            rf_wdata = imm_u;
          end
          OP_AUIPC: begin
            rf_we    = 1'b1;
            rf_wdata = current_pc + imm_u;
          end
          OP_JAL: begin
            rf_we    = 1'b1;
            rf_wdata = pc_plus4;
            pc_n     = current_pc + imm_j;
          end
          OP_JALR: begin
            if (funct3 == 3'b000) begin
              rf_we    = 1'b1;
              rf_wdata = pc_plus4;
              pc_n     = addr_i & ~32'd1;
            end
          end
          OP_BRANCH: begin
            if (br_taken(funct3, rs1_val, rs2_val)) pc_n = current_pc + imm_b;
          end
          OP_LOAD: begin
            if (funct3 == 3'b010) begin
              rd_addr = addr_i >> 2;
              state_n = MEM;
              pc_n    = current_pc;
            end
          end
          OP_STORE: begin
            if (funct3 == 3'b010) begin
              wr_addr = addr_s >> 2;
              wr_data = rs2_val;
              wren    = 1'b1;
            end
          end
          OP_IMM: begin
            if (imm_legal) begin
              rf_we    = 1'b1;
              rf_wdata = alu(funct3, imm_alt, rs1_val, imm_i);
            end
          end
          OP_REG: begin
            if (reg_legal) begin
              rf_we    = 1'b1;
              rf_wdata = alu(funct3, funct7[5], rs1_val, rs2_val);
            end
          end
          default: ;
        endcase
      end
      MEM: begin
        rf_we    = 1'b1;
        rf_wdata = rd_data;
        pc_n     = pc_plus4;
        state_n  = FETCH;
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state      <= FETCH;
      current_pc <= RESET_PC;
      ir         <= '0;
    end else begin
      state      <= state_n;
      current_pc <= pc_n;
      if (ir_load) ir <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_we && (rd != 5'd0)) begin
      regs[rd] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_core.sv
// Directed bench for core: small programs in a behavioural word memory,
// with hand-computed register, PC and memory-port expectations.
module tb_core;

  logic        clk;
  logic        cpu_rstn;
  logic [31:0] rd_addr, wr_addr, wr_data, rd_data;
  logic        wren;

  logic [31:0] mem [256];
  logic        ld_we;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  logic [31:0] prog [32];
  int          plen;
  int          n_checks;
  int          n_errors;

  core #(.RESET_PC(32'h0)) dut (
    .clk      (clk),
    .cpu_rstn (cpu_rstn),
    .rd_addr  (rd_addr),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wren     (wren),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
    else if (wren) mem[wr_addr[7:0]] <= wr_data;
    rd_data <= mem[rd_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] r1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm, r1, f3, rd, op};
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] r2,
                                         input logic [4:0] r1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, r2, r1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] r2,
                                         input logic [4:0] r1);
    return {imm[11:5], r2, r1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] r2,
                                         input logic [4:0] r1, input logic [2:0] f3);
    return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] j_type(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] r1,
                                       input logic [11:0] imm);
    return i_type(imm, r1, 3'b000, rd, 7'b0010011);
  endfunction

  task automatic put(input logic [31:0] w);
    prog[plen] = w;
    plen++;
  endtask

  // Holds reset while the program (and a cleared data word 64) is written.
  task automatic load_and_reset();
    cpu_rstn = 1'b0;
    for (int i = 0; i < plen; i++) begin
      ld_we   = 1'b1;
      ld_addr = 8'(i);
      ld_data = prog[i];
      tick(1);
    end
    ld_we   = 1'b1;
    ld_addr = 8'd64;
    ld_data = 32'd0;
    tick(1);
    ld_we = 1'b0;
    tick(2);
    cpu_rstn = 1'b1;
    #1;
  endtask

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] LOOP = 32'h0000_006F;

  initial begin
    n_checks = 0;
    n_errors = 0;
    ld_we    = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    cpu_rstn = 1'b0;
    plen     = 0;

    tick(3);
    check("rst_pc", dut.current_pc, 32'h0);
    check("rst_rd_addr", rd_addr, 32'h0);
    check("rst_wren", {31'b0, wren}, 32'h0);
    check("rst_wr_addr", wr_addr, 32'h0);

    // Straight-line ALU
    plen = 0;
    put(addi(5'd1, 5'd0, 12'd5));
    put(addi(5'd2, 5'd0, 12'hFFD));
    put(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));
    put(r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd4));
    put(r_type(7'h00, 5'd1, 5'd2, 3'b010, 5'd5));
    put(r_type(7'h00, 5'd2, 5'd1, 3'b011, 5'd11));
    put(r_type(7'h00, 5'd2, 5'd1, 3'b100, 5'd12));
    put(r_type(7'h00, 5'd1, 5'd2, 3'b101, 5'd13));
    put(r_type(7'h00, 5'd1, 5'd1, 3'b001, 5'd14));
    put(i_type(12'h0F0, 5'd2, 3'b111, 5'd15, 7'b0010011));
    put(LOOP);
    load_and_reset();
    check("alu_first_fetch", rd_addr, 32'h0);
    tick(2);
    check("alu_pc_4", dut.current_pc, 32'h4);
    tick(2);
    check("alu_pc_8", dut.current_pc, 32'h8);
    tick(20);
    check("alu_x1", dut.regs[1], 32'd5);
    check("alu_x2", dut.regs[2], 32'hFFFF_FFFD);
    check("alu_add", dut.regs[3], 32'd2);
    check("alu_sub", dut.regs[4], 32'd8);
    check("alu_slt", dut.regs[5], 32'd1);
    check("alu_sltu", dut.regs[11], 32'd1);
    check("alu_xor", dut.regs[12], 32'hFFFF_FFF8);
    check("alu_srl", dut.regs[13], 32'h07FF_FFFF);
    check("alu_sll", dut.regs[14], 32'h0000_00A0);
    check("alu_andi", dut.regs[15], 32'h0000_00F0);

    // Load/store
    plen = 0;
    put(addi(5'd1, 5'd0, 12'h7FF));
    put(s_type(12'd256, 5'd1, 5'd0));
    put(i_type(12'd256, 5'd0, 3'b010, 5'd6, 7'b0000011));
    put(LOOP);
    load_and_reset();
    tick(3);
    check("sw_wren", {31'b0, wren}, 32'd1);
    check("sw_wr_addr", wr_addr, 32'd64);
    check("sw_wr_data", wr_data, 32'h7FF);
    tick(1);
    check("sw_wren_drop", {31'b0, wren}, 32'd0);
    check("lw_fetch_pc", dut.current_pc, 32'h8);
    tick(1);
    check("lw_rd_addr", rd_addr, 32'd64);
    tick(1);
    check("lw_mem_pc", dut.current_pc, 32'h8);
    tick(1);
    check("lw_done_pc", dut.current_pc, 32'hC);
    check("lw_x6", dut.regs[6], 32'h7FF);
    check("sw_mem64", mem[64], 32'h7FF);

    // Control flow: taken BEQ, JAL, JALR
    plen = 0;
    for (int i = 0; i < 4; i++) put(NOP);
    put(b_type(13'd8, 5'd0, 5'd0, 3'b000));
    put(LOOP);
    put(NOP);
    put(NOP);
    put(j_type(21'd16, 5'd1));
    put(LOOP);
    put(NOP);
    put(NOP);
    put(i_type(12'd1, 5'd1, 3'b000, 5'd0, 7'b1100111));
    load_and_reset();
    tick(8);
    check("beq_at_10", dut.current_pc, 32'h10);
    tick(2);
    check("beq_taken", dut.current_pc, 32'h18);
    tick(4);
    check("jal_at_20", dut.current_pc, 32'h20);
    tick(2);
    check("jal_target", dut.current_pc, 32'h30);
    check("jal_link", dut.regs[1], 32'h24);
    tick(2);
    check("jalr_target", dut.current_pc, 32'h24);
    tick(2);
    check("loop_hold", dut.current_pc, 32'h24);

    // Not-taken BNE
    plen = 0;
    for (int i = 0; i < 4; i++) put(NOP);
    put(b_type(13'd8, 5'd0, 5'd0, 3'b001));
    put(LOOP);
    load_and_reset();
    tick(10);
    check("bne_not_taken", dut.current_pc, 32'h14);

    // Edge cases
    plen = 0;
    put(addi(5'd7, 5'd0, 12'd3));
    put(addi(5'd0, 5'd0, 12'd9));
    put(r_type(7'h00, 5'd0, 5'd0, 3'b000, 5'd7));
    put({20'h80000, 5'd9, 7'b0110111});
    put(i_type({7'b0100000, 5'd31}, 5'd9, 3'b101, 5'd10, 7'b0010011));
    put({20'hFFFFF, 5'd8, 7'b0110111});
    put(addi(5'd8, 5'd8, 12'hFFF));
    put(32'h0000_000F);
    put(LOOP);
    load_and_reset();
    tick(14);
    check("fence_at_1c", dut.current_pc, 32'h1C);
    tick(1);
    check("fence_no_store", {31'b0, wren}, 32'd0);
    tick(1);
    check("fence_pc4", dut.current_pc, 32'h20);
    check("x0_discard", dut.regs[7], 32'd0);
    check("lui_80000", dut.regs[9], 32'h8000_0000);
    check("srai_31", dut.regs[10], 32'hFFFF_FFFF);
    check("lui_addi", dut.regs[8], 32'hFFFF_EFFF);
    check("fence_no_write", dut.regs[11], 32'd0);

    // Async reset during the SW EXEC cycle
    plen = 0;
    put(addi(5'd1, 5'd0, 12'h7FF));
    put(s_type(12'd256, 5'd1, 5'd0));
    put(i_type(12'd256, 5'd0, 3'b010, 5'd6, 7'b0000011));
    put(LOOP);
    load_and_reset();
    tick(3);
    check("abort_pre_wren", {31'b0, wren}, 32'd1);
    cpu_rstn = 1'b0;
    #1;
    check("abort_wren", {31'b0, wren}, 32'd0);
    check("abort_pc", dut.current_pc, 32'h0);
    check("abort_x1", dut.regs[1], 32'd0);
    tick(2);
    check("abort_no_write", mem[64], 32'd0);
    cpu_rstn = 1'b1;
    #1;
    check("restart_rd_addr", rd_addr, 32'h0);
    tick(9);
    check("restart_pc", dut.current_pc, 32'hC);
    check("restart_x6", dut.regs[6], 32'h7FF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
